seq_det_ctrl: RTL and testbench

Controller that sequences a serial Mealy pattern detector.
- Accepts a parallel data word on a start handshake.
- Shifts the word out MSB-first, one bit per clock, through an internal detector.
- The detector pattern is programmable.
- Counts overlapping matches and reports completion with a one-cycle done pulse.
- Sits between a register/host interface and the serial detection datapath; the host configures and launches, the block schedules the bit stream.

---
 rtl/seq_det_ctrl_pkg.sv | 15 +
 rtl/seq_det_ctrl_match_core.sv | 46 ++++
 rtl/seq_det_ctrl.sv | 124 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_ctrl_pkg.sv
// Shared definitions for the serial pattern detector controller.
// Holds the FSM state encoding and the power-up pattern value.
// Imported by the controller and its match core.
package seq_det_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b11
  } state_e;

  // Pattern loaded at reset when the default pattern length is used
  localparam logic [2:0] DEF_PAT = 3'b101;

endpackage

// File: rtl/seq_det_ctrl_match_core.sv
// Mealy match core: keeps the last PW-1 serial bits and a valid-bit count.
// match_o is combinational from the presented bit, gated by act_i.
// clr_i wipes the history per operation so matches never span two words.
module seq_match_core
  import seq_det_ctrl_pkg::*;
#(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic          act_i,
  input  logic          bit_i,
  input  logic [PW-1:0] pat_i,
  output logic          match_o
);

  localparam int VW = (PW > 2) ? $clog2(PW) : 1;
  localparam logic [VW-1:0] VMAX = VW'(PW - 1);

  logic [PW-2:0] hist_q;
  logic [PW-2:0] hist_d;
  logic [VW-1:0] vcnt_q;
  logic [PW-1:0] window;

  // Current candidate window: stored history followed by the live bit
  assign window  = {hist_q, bit_i};
  assign hist_d  = window[PW-2:0];
  assign match_o = act_i && (vcnt_q == VMAX) && (window == pat_i);

  // History shift register and saturating count of bits seen this operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      vcnt_q <= '0;
    end else if (clr_i) begin
      hist_q <= '0;
      vcnt_q <= '0;
    end else if (shift_i) begin
      hist_q <= hist_d;
      if (vcnt_q != VMAX) vcnt_q <= vcnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Controller that serialises a data word MSB-first into a programmable pattern detector.
// Latency: start at edge k, bits presented for DW cycles, done pulses in cycle k+DW..k+DW+1.
// No backpressure: start and cfg_we are ignored (not queued) while busy or done.
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int             DW      = 8,
  parameter int             PW      = 3,
  parameter int             CW      = 4,
  parameter logic [PW-1:0]  RST_PAT = PW'(DEF_PAT)
) (
  input  logic          clk,
  input  logic          R,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pat,
  input  logic          start,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic          bit_out,
  output logic          X,
  output logic [CW-1:0] match_cnt,
  output logic          overflow
);

  localparam int             IW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(DW - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  state_e        state_q;
  logic [DW-1:0] shift_q;
  logic [IW-1:0] idx_q;
  logic [PW-1:0] pat_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          busy_q;
  logic          done_q;
  logic          match_w;
  logic          launch_w;

  assign launch_w = (state_q == ST_IDLE) && start;

  seq_match_core #(
    .PW(PW)
  ) u_core (
    .clk    (clk),
    .rst    (R),
    .clr_i  (launch_w),
    .shift_i(busy_q),
    .act_i  (busy_q),
    .bit_i  (bit_out),
    .pat_i  (pat_q),
    .match_o(match_w)
  );

  // Saturating match counter; a match while already saturated marks overflow
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (match_w) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  // Sequencing FSM with its datapath registers and registered status outputs
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      pat_q   <= RST_PAT;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The pattern write lands in the same edge, so it applies to this launch
          if (cfg_we) pat_q <= cfg_pat;
          if (start) begin
            shift_q <= din;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_q <= {shift_q[DW-2:0], 1'b0};
          idx_q   <= idx_q + 1'b1;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_out   = busy_q & shift_q[DW-1];
  assign X         = match_w;
  assign match_cnt = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: a per-bit scoreboard of {bit_out, X}
// plus per-scenario checks of latency, done pulses, counts and overflow.
// A second instance with a 2-bit counter exercises saturation.
module tb_seq_det_ctrl;

  localparam int DW = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          R;
  logic          cfg_we;
  logic [PW-1:0] cfg_pat;
  logic          start;
  logic [DW-1:0] din;

  logic          busy, done, bit_out, X, overflow;
  logic [3:0]    match_cnt;
  logic          busy2, done2, bit_out2, X2, overflow2;
  logic [1:0]    match_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  logic [1:0] sb[$];
  logic [1:0] exp_e;
  logic [PW-1:0] model_pat;

  seq_det_ctrl #(.DW(DW), .PW(PW), .CW(4)) u_dut (
    .clk(clk), .R(R), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .start(start), .din(din),
    .busy(busy), .done(done), .bit_out(bit_out), .X(X),
    .match_cnt(match_cnt), .overflow(overflow)
  );

  seq_det_ctrl #(.DW(DW), .PW(PW), .CW(2)) u_dut2 (
    .clk(clk), .R(R), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .start(start), .din(din),
    .busy(busy2), .done(done2), .bit_out(bit_out2), .X(X2),
    .match_cnt(match_cnt2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every SHIFT cycle pops one expected {bit_out, X}
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: busy at cyc %0d with no expected bit queued", cyc);
      end else begin
        exp_e = sb.pop_front();
        if ({bit_out, X} !== exp_e || {bit_out2, X2} !== exp_e) begin
          n_bad++;
          $display("FAIL stream: {bit_out,X}=%b dut2=%b expected %b at cyc %0d",
                   {bit_out, X}, {bit_out2, X2}, exp_e, cyc);
        end
      end
    end else begin
      n_cmp++;
      if ({bit_out, X, bit_out2, X2} !== 4'b0000) begin
        n_bad++;
        $display("FAIL idle_out: {bit_out,X,bit_out2,X2}=%b expected 0000 at cyc %0d",
                 {bit_out, X, bit_out2, X2}, cyc);
      end
    end
  end

  // Drive a start (optionally with a simultaneous pattern write) and queue expectations
  task automatic launch(input logic [DW-1:0] d, input bit wcfg, input logic [PW-1:0] p);
    logic b, x;
    @(negedge clk);
    din   = d;
    start = 1'b1;
    if (wcfg) begin
      cfg_we    = 1'b1;
      cfg_pat   = p;
      model_pat = p;
    end
    for (int i = 0; i < DW; i++) begin
      b = d[DW-1-i];
      if (i >= PW - 1) x = ({d[DW+1-i], d[DW-i], d[DW-1-i]} == model_pat);
      else             x = 1'b0;
      sb.push_back({b, x});
    end
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
    cfg_we    = 1'b0;
  endtask

  // Pattern write while idle
  task automatic write_pat(input logic [PW-1:0] p);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_pat   = p;
    model_pat = p;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // Bounded wait for done; lat is edges from the start edge, -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 0; n < DW + 6; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - start_cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    R = 1'b1; cfg_we = 1'b0; cfg_pat = '0; start = 1'b0; din = '0;
    model_pat = 3'b101;
    #12;
    n_cmp++;
    if ({busy, done, bit_out, X, match_cnt, overflow, busy2, done2, match_cnt2, overflow2} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: outputs=%b expected all zero",
               {busy, done, bit_out, X, match_cnt, overflow, busy2, done2, match_cnt2, overflow2});
    end
    @(negedge clk);
    R = 1'b0;
  endtask

  task automatic test_basic;
    int lat, d0;
    d0 = done_cnt;
    launch(8'b10101010, 1'b0, '0);
    wait_done(lat);
    n_cmp++;
    if (lat !== DW) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", lat, DW); end
    @(negedge clk);
    n_cmp++;
    if ({done, match_cnt, overflow, match_cnt2, overflow2} !== {1'b0, 4'd3, 1'b0, 2'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_result: done=%b cnt=%0d ovf=%b cnt2=%0d ovf2=%b expected 0/3/0/3/0",
               done, match_cnt, overflow, match_cnt2, overflow2);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL basic_pulses: done pulses=%0d left=%0d expected 1/0", done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_all_ones;
    int lat;
    write_pat(3'b111);
    launch(8'hFF, 1'b0, '0);
    wait_done(lat);
    n_cmp++;
    if (lat !== DW) begin n_bad++; $display("FAIL ones_latency: got %0d expected %0d", lat, DW); end
    @(negedge clk);
    n_cmp++;
    if ({match_cnt, overflow} !== {4'd6, 1'b0}) begin
      n_bad++;
      $display("FAIL ones_cnt: cnt=%0d ovf=%b expected 6/0", match_cnt, overflow);
    end
    n_cmp++;
    if ({match_cnt2, overflow2} !== {2'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL ones_saturate: cnt2=%0d ovf2=%b expected 3/1", match_cnt2, overflow2);
    end
    write_pat(3'b101);
  endtask

  task automatic test_zero_ignored_start;
    int lat, d0;
    d0 = done_cnt;
    launch(8'h00, 1'b0, '0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    din   = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    n_cmp++;
    if (lat !== DW) begin n_bad++; $display("FAIL zero_latency: got %0d expected %0d", lat, DW); end
    @(negedge clk);
    n_cmp++;
    if ({match_cnt, overflow, match_cnt2} !== {4'd0, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL zero_cnt: cnt=%0d ovf=%b cnt2=%0d expected 0/0/0", match_cnt, overflow, match_cnt2);
    end
    repeat (DW + 2) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL ignored_start: done pulses=%0d busy=%b left=%0d expected 1/0/0",
               done_cnt - d0, busy, sb.size());
    end
  endtask

  task automatic test_cfg_frozen;
    int lat;
    launch(8'hAA, 1'b0, '0);
    repeat (2) @(negedge clk);
    cfg_we  = 1'b1;
    cfg_pat = 3'b000;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    wait_done(lat);
    @(negedge clk);
    n_cmp++;
    if (lat !== DW || match_cnt !== 4'd3) begin
      n_bad++;
      $display("FAIL frozen_run: lat=%0d cnt=%0d expected %0d/3", lat, match_cnt, DW);
    end
    launch(8'h00, 1'b0, '0);
    wait_done(lat);
    @(negedge clk);
    n_cmp++;
    if (lat !== DW || match_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL frozen_next: lat=%0d cnt=%0d expected %0d/0", lat, match_cnt, DW);
    end
  endtask

  task automatic test_reset_mid_shift;
    int lat, d0;
    write_pat(3'b111);
    launch(8'hFF, 1'b0, '0);
    repeat (5) @(negedge clk);
    #2;
    d0 = done_cnt;
    R  = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, bit_out, X, match_cnt, overflow, match_cnt2} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: busy=%b done=%b bit=%b X=%b cnt=%0d ovf=%b cnt2=%0d expected all 0",
               busy, done, bit_out, X, match_cnt, overflow, match_cnt2);
    end
    sb.delete();
    model_pat = 3'b101;
    @(negedge clk);
    R = 1'b0;
    repeat (DW + 3) @(negedge clk);
    n_cmp++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_nodone: done pulses=%0d busy=%b expected 0/0", done_cnt - d0, busy);
    end
    launch(8'hAA, 1'b0, '0);
    wait_done(lat);
    @(negedge clk);
    n_cmp++;
    if (lat !== DW || {match_cnt, overflow} !== {4'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset_after: lat=%0d cnt=%0d ovf=%b expected %0d/3/0", lat, match_cnt, overflow, DW);
    end
  endtask

  task automatic test_cfg_with_start;
    int lat;
    launch(8'b00110011, 1'b1, 3'b011);
    wait_done(lat);
    @(negedge clk);
    n_cmp++;
    if (lat !== DW || {match_cnt, overflow, match_cnt2, overflow2} !== {4'd2, 1'b0, 2'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL cfg_with_start: lat=%0d cnt=%0d ovf=%b cnt2=%0d ovf2=%b expected %0d/2/0/2/0",
               lat, match_cnt, overflow, match_cnt2, overflow2, DW);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: %0d expected entries never observed", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_zero_ignored_start();
    test_cfg_frozen();
    test_reset_mid_shift();
    test_cfg_with_start();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
